// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: state encoding and counter sizing.
// The state constants stay as plain localparams so older code can compare against raw bits.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_CORE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HOST  = 2'd2;
    localparam logic [1:0] ST_YIELD = 2'd3;

    typedef enum logic [1:0] {
        CORE  = ST_CORE,
        DRAIN = ST_DRAIN,
        HOST  = ST_HOST,
        YIELD = ST_YIELD
    } arb_state_t;

    // A counter that only ever holds zero still needs one bit to exist.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_flopenr.sv
// Two-phase enabled register with synchronous reset: the master stage samples on ph2,
// and the slave stage presents the sampled value on the following ph1.
module mem_port_arbiter_flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             ph1,
    input  logic             ph2,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] master;

    always_ff @(posedge ph2) begin
        if (reset)
            master <= '0;
        else if (en)
            master <= d;
    end

    always_ff @(posedge ph1) begin
        q <= master;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between the core and a host loader/debug port. The core is
// stalled only at an instruction boundary, and host bursts are capped so the core keeps running.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW           = 8,
    parameter int DW           = 8,
    parameter int MAX_BURST    = 4,
    parameter int YIELD_CYCLES = 2
) (
    input  logic          ph1,
    input  logic          ph2,
    input  logic          reset,
    input  logic [AW-1:0] core_adr,
    input  logic          core_we,
    input  logic [DW-1:0] core_wdata,
    input  logic          core_boundary,
    output logic          core_hold,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_adr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic [AW-1:0] mem_adr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int BW = cnt_width(MAX_BURST);
    localparam int YW = cnt_width(YIELD_CYCLES);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [YW-1:0] YIELD_LAST = YW'(YIELD_CYCLES - 1);

    logic [1:0]    state_q;
    arb_state_t    state;
    arb_state_t    state_next;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_next;
    logic [YW-1:0] yield_cnt;
    logic [YW-1:0] yield_next;
    logic          hold;
    logic          gnt;
    logic          host_owns;
    logic          read_grant;

    assign state = arb_state_t'(state_q);

    // Arbitration: the core reaches a fetch boundary before the host takes over, and a full
    // burst always hands the port back for a short window. Reset masks hold and grant at once.
    always_comb begin
        state_next = state;
        burst_next = burst_cnt;
        yield_next = yield_cnt;
        hold       = 1'b0;
        gnt        = 1'b0;
        host_owns  = 1'b0;
        case (state)
            CORE: begin
                if (host_req)
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (!host_req) begin
                    state_next = CORE;
                end else if (core_boundary) begin
                    hold       = 1'b1;
                    state_next = HOST;
                end
            end
            HOST: begin
                host_owns = 1'b1;
                hold      = 1'b1;
                if (host_req) begin
                    gnt = 1'b1;
                    if (burst_cnt >= BURST_LAST) begin
                        burst_next = '0;
                        state_next = YIELD;
                    end else begin
                        burst_next = burst_cnt + 1'b1;
                    end
                end else begin
                    burst_next = '0;
                    state_next = CORE;
                end
            end
            YIELD: begin
                if (yield_cnt >= YIELD_LAST) begin
                    yield_next = '0;
                    state_next = CORE;
                end else begin
                    yield_next = yield_cnt + 1'b1;
                end
            end
            default: begin
                state_next = CORE;
            end
        endcase
        if (reset) begin
            hold = 1'b0;
            gnt  = 1'b0;
        end
    end

    assign read_grant = gnt & ~host_we;
    assign core_hold  = hold;
    assign host_gnt   = gnt;

    // The host write strobe only reaches memory on a real grant, so the cycle in which the
    // host drops its request cannot write a stale address.
    assign mem_adr   = host_owns ? host_adr   : core_adr;
    assign mem_wdata = host_owns ? host_wdata : core_wdata;
    assign mem_we    = ~reset & (host_owns ? (gnt & host_we) : core_we);

    mem_port_arbiter_flopenr #(.WIDTH(2)) u_state (
        .ph1   (ph1),
        .ph2   (ph2),
        .reset (reset),
        .en    (1'b1),
        .d     (state_next),
        .q     (state_q)
    );

    mem_port_arbiter_flopenr #(.WIDTH(BW)) u_burst_cnt (
        .ph1   (ph1),
        .ph2   (ph2),
        .reset (reset),
        .en    (1'b1),
        .d     (burst_next),
        .q     (burst_cnt)
    );

    mem_port_arbiter_flopenr #(.WIDTH(YW)) u_yield_cnt (
        .ph1   (ph1),
        .ph2   (ph2),
        .reset (reset),
        .en    (1'b1),
        .d     (yield_next),
        .q     (yield_cnt)
    );

    mem_port_arbiter_flopenr #(.WIDTH(DW)) u_host_rdata (
        .ph1   (ph1),
        .ph2   (ph2),
        .reset (reset),
        .en    (read_grant),
        .d     (mem_rdata),
        .q     (host_rdata)
    );

    mem_port_arbiter_flopenr #(.WIDTH(1)) u_host_rvalid (
        .ph1   (ph1),
        .ph2   (ph2),
        .reset (reset),
        .en    (1'b1),
        .d     (read_grant),
        .q     (host_rvalid)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a toy three-cycle core and a byte memory around the arbiter,
// checked every cycle against a rule-level model of who owns the port.
module tb_mem_port_arbiter;

    localparam int AW           = 8;
    localparam int DW           = 8;
    localparam int MAX_BURST    = 4;
    localparam int YIELD_CYCLES = 2;

    logic          ph1, ph2, reset;
    logic [AW-1:0] core_adr, host_adr, mem_adr;
    logic          core_we, core_boundary, core_hold;
    logic [DW-1:0] core_wdata, host_wdata, host_rdata, mem_wdata, mem_rdata;
    logic          host_req, host_we, host_gnt, host_rvalid, mem_we;

    logic [7:0] ref_mem [256];
    assign mem_rdata = ref_mem[mem_adr];

    // Rule-level model: who owns the port, how many grants remain, how long the yield lasts.
    bit         m_host, m_drain;
    int         m_grants_left, m_yield_left;
    logic       exp_rvalid;
    logic [7:0] exp_rdata;

    int         core_phase;
    logic [7:0] core_pc;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .YIELD_CYCLES(YIELD_CYCLES)
    ) dut (
        .ph1(ph1), .ph2(ph2), .reset(reset),
        .core_adr(core_adr), .core_we(core_we), .core_wdata(core_wdata),
        .core_boundary(core_boundary), .core_hold(core_hold),
        .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mem_adr(mem_adr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        ph1 = 0;
        ph2 = 0;
        forever begin
            #1 ph1 = 1;
            #3 ph1 = 0;
            #1 ph2 = 1;
            #3 ph2 = 0;
            #2;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model past the cycle.
    task automatic checkOutput();
        logic       e_hold, e_gnt, e_we, next_rvalid;
        logic [7:0] e_adr, e_wdata;
        e_hold = 1'b0;
        e_gnt  = 1'b0;
        if (m_host) begin
            e_hold = 1'b1;
            e_gnt  = host_req;
        end else if (m_yield_left == 0 && m_drain) begin
            e_hold = core_boundary && host_req;
        end
        e_adr   = m_host ? host_adr : core_adr;
        e_wdata = m_host ? host_wdata : core_wdata;
        e_we    = m_host ? (e_gnt && host_we) : core_we;
        if (reset) begin
            e_hold = 1'b0;
            e_gnt  = 1'b0;
            e_we   = 1'b0;
        end
        check("core_hold", core_hold, e_hold);
        check("host_gnt", host_gnt, e_gnt);
        check("mem_we", mem_we, e_we);
        if (!reset) begin
            check("mem_adr", mem_adr, e_adr);
            check("mem_wdata", mem_wdata, e_wdata);
            check("host_rvalid", host_rvalid, exp_rvalid);
            check("host_rdata", host_rdata, exp_rdata);
        end

        next_rvalid = e_gnt && !host_we;
        if (next_rvalid)
            exp_rdata = ref_mem[host_adr];
        if (e_we)
            ref_mem[e_adr] = e_wdata;
        if (reset) begin
            m_host        = 0;
            m_drain       = 0;
            m_grants_left = MAX_BURST;
            m_yield_left  = 0;
            exp_rdata     = 8'h00;
        end else if (m_host) begin
            m_host = 0;
            if (host_req) begin
                m_grants_left--;
                if (m_grants_left == 0) begin
                    m_grants_left = MAX_BURST;
                    m_yield_left  = YIELD_CYCLES;
                end else begin
                    m_host = 1;
                end
            end else begin
                m_grants_left = MAX_BURST;
            end
        end else if (m_yield_left > 0) begin
            m_yield_left--;
        end else if (m_drain) begin
            if (!host_req) begin
                m_drain = 0;
            end else if (core_boundary) begin
                m_drain = 0;
                m_host  = 1;
            end
        end else if (host_req) begin
            m_drain = 1;
        end
        exp_rvalid = reset ? 1'b0 : next_rvalid;
    endtask

    // One cycle: drive host and core inputs after ph1, check before ph2, then step the toy core.
    task automatic applyStimulus(input logic rst, input logic req, input logic we,
                                 input logic [7:0] adr, input logic [7:0] wdata);
        @(posedge ph1);
        #1;
        reset         = rst;
        host_req      = req;
        host_we       = we;
        host_adr      = adr;
        host_wdata    = wdata;
        core_boundary = (core_phase == 0);
        core_adr      = (core_phase == 0) ? core_pc : {1'b1, core_pc[6:0]};
        core_we       = (core_phase == 2) && core_pc[0];
        core_wdata    = core_pc ^ 8'h5A;
        #1;
        checkOutput();
        if (rst) begin
            core_phase = 0;
            core_pc    = 8'h00;
        end else if (!core_hold) begin
            if (core_phase == 2) begin
                core_phase = 0;
                core_pc    = core_pc + 8'h01;
            end else begin
                core_phase++;
            end
        end
    endtask

    task automatic hostAccess(input logic we, input logic [7:0] adr, input logic [7:0] wdata,
                              input string tag);
        int   n = 0;
        logic prev_hold = 1'b0;
        do begin
            applyStimulus(1'b0, 1'b1, we, adr, wdata);
            n++;
            if (core_hold && !prev_hold)
                check({tag, "_hold_at_boundary"}, core_boundary, 1'b1);
            prev_hold = core_hold;
        end while (!host_gnt && n < 20);
        check({tag, "_granted"}, host_gnt, 1'b1);
        if (host_gnt) begin
            check({tag, "_adr"}, mem_adr, adr);
            check({tag, "_we"}, mem_we, we);
        end
    endtask

    initial begin
        int         grants, cyc, quiet_left, n;
        logic [7:0] pc_at4;
        logic       r_req, r_we, gnt_last, rst;
        logic [7:0] r_adr, r_wd;

        for (int i = 0; i < 256; i++)
            ref_mem[i] = 8'(i * 7 + 3);
        m_host        = 0;
        m_drain       = 0;
        m_grants_left = MAX_BURST;
        m_yield_left  = 0;
        exp_rvalid    = 1'b0;
        exp_rdata     = 8'h00;
        core_phase    = 0;
        core_pc       = 8'h00;
        reset = 1; host_req = 1; host_we = 0; host_adr = 0; host_wdata = 0;
        core_adr = 0; core_we = 0; core_wdata = 0; core_boundary = 1;

        $display("[TB] reset with host_req held high");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t1_core_owns", mem_adr, core_adr);
        check("t1_rvalid", host_rvalid, 1'b0);

        $display("[TB] host write while the core is mid-instruction");
        n = 0;
        while (core_phase != 1 && n < 6) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            n++;
        end
        hostAccess(1'b1, 8'h10, 8'hA5, "t2");
        check("t2_wdata", mem_wdata, 8'hA5);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t2_mem_written", ref_mem[8'h10], 8'hA5);

        $display("[TB] host read of a preloaded byte");
        ref_mem[8'h20] = 8'h3C;
        hostAccess(1'b0, 8'h20, 8'h00, "t3");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t3_rvalid", host_rvalid, 1'b1);
        check("t3_rdata", host_rdata, 8'h3C);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t3_rvalid_pulse", host_rvalid, 1'b0);

        $display("[TB] six-access burst against the burst limit");
        grants = 0;
        cyc = 0;
        quiet_left = 0;
        pc_at4 = 8'h00;
        while (grants < 6 && cyc < 80) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h40 + grants), 8'h00);
            cyc++;
            if (quiet_left > 0) begin
                check("t4_yield_gnt", host_gnt, 1'b0);
                check("t4_yield_hold", core_hold, 1'b0);
                quiet_left--;
            end
            if (host_gnt) begin
                grants++;
                if (grants == 4) begin
                    pc_at4 = core_pc;
                    quiet_left = YIELD_CYCLES;
                end
                if (grants == 5)
                    check("t4_core_progress", 8'(core_pc - pc_at4), 8'h01);
            end
        end
        check("t4_grants", grants, 6);

        $display("[TB] request withdrawn before the core reaches a boundary");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        n = 0;
        while (core_phase != 1 && n < 6) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            n++;
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h55, 8'h00);
        check("t5_hold_a", core_hold, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h55, 8'h00);
        check("t5_hold_b", core_hold, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h55, 8'h00);
        check("t5_hold_c", core_hold, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t5_no_gnt", host_gnt, 1'b0);

        $display("[TB] reset in the middle of a burst");
        hostAccess(1'b1, 8'h30, 8'h11, "t6");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h31, 8'h00);
        check("t6_second_gnt", host_gnt, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h32, 8'h00);
        check("t6_reset_gnt", host_gnt, 1'b0);
        check("t6_reset_we", mem_we, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h32, 8'h00);
        check("t6_hold_after", core_hold, 1'b0);
        check("t6_rvalid_after", host_rvalid, 1'b0);

        $display("[TB] randomized traffic");
        r_req = 0; r_we = 0; r_adr = 0; r_wd = 0; gnt_last = 0;
        repeat (400) begin
            rst = ($urandom_range(0, 59) == 0);
            if (!r_req || gnt_last) begin
                r_req = ($urandom_range(0, 2) != 0);
                r_we  = 1'($urandom_range(0, 1));
                r_adr = 8'($urandom);
                r_wd  = 8'($urandom);
            end else if ($urandom_range(0, 29) == 0) begin
                r_req = 0;
            end
            applyStimulus(rst, r_req, r_we, r_adr, r_wd);
            gnt_last = host_gnt;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
